// File: rtl/quant_result_drain_if.sv
// quant_result_drain_if: row-beat valid/ready stream from the drain.
// master drives valid/data/row/last, slave drives ready.
interface quant_result_drain_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ROW_W =
    (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
);
  logic                             m_valid;
  logic                             m_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] m_data;
  logic [ROW_W-1:0]                 m_row;
  logic                             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_row,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/quant_result_drain.sv
// quant_result_drain: ping-pong capture of quant matrices, row streaming.
// Ports: clk, reset_n, quant_out/quant_valid, flush, m (row stream), status.
module quant_result_drain #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ROW_W =
    (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] quant_out
                                       [ARRAY_SIZE][ARRAY_SIZE],
  input  logic                         quant_valid,
  input  logic                         flush,
  quant_result_drain_if.master         m,
  output logic                         capture_ready,
  output logic                         busy,
  output logic                         dropped,
  output logic [7:0]                   drop_count
);

  localparam int DW = ARRAY_SIZE * DATA_WIDTH;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(ARRAY_SIZE - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic signed [DATA_WIDTH-1:0] bank_q
    [2][ARRAY_SIZE][ARRAY_SIZE];

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       full_q, full_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             qv_q;

  logic             trig, hs, fin;
  logic [1:0]       freed, avail_full;
  logic             cap, cap_bank, drop;

  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             cap_rdy_d, busy_d;

  assign m.m_valid     = m_valid_q;
  assign m.m_last      = m_last_q;
  assign m.m_data      = m_data_q;
  assign m.m_row       = row_q;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      row_q         <= '0;
      full_q        <= '0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      qv_q          <= 1'b0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= '0;
      capture_ready <= 1'b1;
      busy          <= 1'b0;
      dropped       <= 1'b0;
      drop_count    <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      full_q        <= full_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      qv_q          <= quant_valid;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_data_q      <= m_data_d;
      capture_ready <= cap_rdy_d;
      busy          <= busy_d;
      if (drop) begin
        dropped <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

  // matrix storage needs no reset; full flags qualify it
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int r = 0; r < ARRAY_SIZE; r++)
        for (int c = 0; c < ARRAY_SIZE; c++)
          bank_q[cap_bank][r][c] <= quant_out[r][c];
    end
  end

  // next state
  always_comb begin
    trig       = quant_valid && !qv_q;
    hs         = m_valid_q && m.m_ready;
    fin        = hs && (row_q == LAST);
    freed      = fin ? (2'b01 << rd_q) : 2'b00;
    // a bank drained this cycle is already free to the trigger
    avail_full = full_q & ~freed;

    state_d  = state_q;
    row_d    = row_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    full_d   = avail_full;
    cap      = 1'b0;
    cap_bank = wr_q;
    drop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (full_q[rd_q]) begin
          state_d = SEND;
          row_d   = '0;
        end
      end
      SEND: begin
        if (fin) begin
          rd_d  = ~rd_q;
          row_d = '0;
          if (!full_q[~rd_q])
            state_d = IDLE;
        end else if (hs) begin
          row_d = row_q + 1'b1;
        end
      end
    endcase

    if (trig) begin
      unique case (1'b1)
        (avail_full == 2'b00): begin
          // empty store restarts at bank 0
          cap      = 1'b1;
          cap_bank = 1'b0;
          wr_d     = 1'b1;
          rd_d     = 1'b0;
        end
        (&avail_full): begin
          drop = 1'b1;
        end
        default: begin
          cap      = 1'b1;
          cap_bank = wr_q;
          wr_d     = ~wr_q;
        end
      endcase
      if (cap)
        full_d[cap_bank] = 1'b1;
    end

    if (flush) begin
      state_d = IDLE;
      row_d   = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      full_d  = '0;
      cap     = 1'b0;
      drop    = 1'b0;
    end
  end

  // registered outputs
  always_comb begin
    m_valid_d = (state_d == SEND);
    m_last_d  = m_valid_d && (row_d == LAST);
    m_data_d  = m_data_q;
    if (m_valid_d) begin
      for (int c = 0; c < ARRAY_SIZE; c++)
        m_data_d[c*DATA_WIDTH +: DATA_WIDTH] =
          bank_q[rd_d][row_d][c];
    end
    cap_rdy_d = ~&full_d;
    busy_d    = (|full_d) || m_valid_d;
  end

endmodule

// File: doc/quant_result_drain.md
# quant_result_drain

Output-side drain for the systolic-quant pipeline. Captures the full ARRAY_SIZE×ARRAY_SIZE quantized result matrix when `quant_valid` rises, and buffers it in a two-bank ping-pong store. Streams the matrix out one row per beat over a valid/ready interface toward the output buffer or DMA writer. It is the consumer end of the `quant_out`/`quant_valid` interface.

## Interface
- `ARRAY_SIZE`, 4: matrix dimension (rows = cols).
- `DATA_WIDTH`, 8: quantized element width, signed.
- `ROW_W`, `$clog2(ARRAY_SIZE)` (min 1): row index width.
- `clk`  in  1  sole clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `quant_out`  in  signed [DATA_WIDTH-1:0] [ARRAY_SIZE][ARRAY_SIZE]  quantized matrix, `[row][col]`.
- `quant_valid`  in  1  level valid from the quant stage; may stay high many cycles.
- `flush`  in  1  synchronous discard of all buffered matrices.
- `m_valid`  out  1  output row beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  ARRAY_SIZE*DATA_WIDTH  one row; column c at `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `m_row`  out  ROW_W  row index of current beat.
- `m_last`  out  1  high on row ARRAY_SIZE-1.
- `capture_ready`  out  1  at least one bank free.
- `busy`  out  1  any bank full or beat pending.
- `dropped`  out  1  sticky: a matrix was lost to overflow.
- `drop_count`  out  8  saturating count of lost matrices.

## Operation
- Capture trigger is the rising edge of `quant_valid`: `quant_valid && !quant_valid_q`. `quant_valid_q` resets to 0, so a level already high after reset counts as one edge. A held-high level produces exactly one capture.
- On a trigger, the full matrix is copied into the free bank, and that bank is marked full.
  - Both banks free: bank 0 is used.
  - One bank free: that bank is used.
  - Both banks full: the matrix is dropped. `dropped` is set and `drop_count` increments, saturating at 255.
- Banks drain in capture order; a write pointer and a read pointer each toggle per use.
- Drain FSM:
  - IDLE: `m_valid` = 0. Go to SEND when the read bank is full.
  - SEND: present row `m_row` of the read bank. Advance `m_row` on each `m_valid && m_ready` handshake.
  - On the handshake of row ARRAY_SIZE-1, free the bank and toggle the read pointer. If the other bank is full, stay in SEND at row 0 with no bubble; otherwise go to IDLE.
- Simultaneous events:
  - A bank freed by the final-row handshake in cycle t is available to a trigger in the same cycle t, so no drop occurs.
  - Trigger and drain never touch the same bank.
- Beat stability: while `m_valid && !m_ready`, `m_data`, `m_row` and `m_last` hold constant.
- `flush` (priority over capture and drain):
  - Clears both bank-full flags and both pointers; FSM goes to IDLE.
  - `m_valid` is 0 the next cycle, and a trigger in the same cycle is discarded.
  - `dropped` and `drop_count` are not affected.
- Element values are passed through bit-exact; no sign or width conversion.

## Timing
- Reset values:
  - `m_valid`, `m_last`, `busy`, `dropped` = 0.
  - `m_data`, `m_row`, `drop_count` = 0.
  - `capture_ready` = 1.
  - FSM = IDLE, pointers = 0, bank flags = 0.
- Reset asserted mid-drain aborts immediately and asynchronously to the values above; buffered data is lost.
- Latency: a trigger sampled at edge t gives `m_valid` = 1 with row 0 from edge t+1 (registered outputs).
- Throughput: one row per cycle with `m_ready` held high. A matrix takes ARRAY_SIZE cycles, and back-to-back matrices are gap-free.
- `capture_ready` and `busy` are registered and reflect state after the current edge.

## Test plan
- Single matrix:
  - Stimulus: `quant_out[i][j] = i*4+j`, `quant_valid` high 1 cycle, `m_ready` = 1.
  - Response: 4 beats starting the cycle after the trigger: `m_data` = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; `m_row` 0..3; `m_last` only on the 4th beat; then `m_valid` = 0, `busy` = 0.
- Level-held valid:
  - Stimulus: `quant_valid` high 20 cycles, all elements -7.
  - Response: exactly 4 beats, each `m_data` = 0xF9F9F9F9; `drop_count` = 0.
- Backpressure:
  - Stimulus: `m_ready` toggles 1,0,0,1,…
  - Response: each beat is held unchanged during the 0 cycles; all 4 rows are delivered in order with none duplicated.
- Overflow:
  - Stimulus: `m_ready` = 0; three triggers with matrices filled 1, 2, 3.
  - Response: `capture_ready` = 0 after the 2nd trigger; after the 3rd, `dropped` = 1 and `drop_count` = 1. Releasing `m_ready` yields 4 beats of 0x01010101 then 4 beats of 0x02020202, with no gap between them.
- Free-and-capture same cycle:
  - Stimulus: both banks full, and a trigger coincides with the final-row handshake.
  - Response: no drop; the new matrix streams after the remaining bank.
- Flush and reset:
  - Stimulus: `flush` mid-drain at row 2.
  - Response: `m_valid` = 0 next cycle; a new trigger restarts at row 0; `drop_count` is unchanged.
  - Stimulus: `reset_n` low mid-drain.
  - Response: all outputs at reset values within the same cycle.
